peak_window_detector: RTL and testbench
=======================================

# peak_window_detector

Parametrised windowed peak detector, successor to the fixed 20-bit `max_value` block. It subtracts a baseline from each enabled sample with saturation at zero. Over a window of exactly `WINDOW` accepted samples it tracks the largest corrected value, its index and (optionally) the second-largest value. At each window end it publishes a registered result with a one-cycle valid pulse and restarts without dropping samples. It sits after the sample front-end and feeds the peak-reporting logic.

## Interface
- `DATA_W`, default 20: sample, baseline and result width.
- `WINDOW`, default 24: accepted samples per window; legal range is 2 or more.
- `IDX_W`, default `$clog2(WINDOW)`: localparam; width of index and count.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `n_rst`, input, 1: reset, asynchronous and active-low.
- `clear`, input, 1: synchronous abort of the current window.
- `sample_en`, input, 1: `data_input` is valid this cycle.
- `baseline_value`, input, `DATA_W`: baseline applied to the concurrent sample.
- `data_input`, input, `DATA_W`: raw sample.
- `peak_value`, output, `DATA_W`: maximum corrected value of the last completed window.
- `second_value`, output, `DATA_W`: second-largest corrected value of the last completed window.
- `peak_index`, output, `IDX_W`: position of `peak_value` within its window, 0-based.
- `peak_valid`, output, 1: one-cycle pulse when the result registers update.
- `busy`, output, 1: high while the FSM is in ACCUM.
- `sample_count`, output, `IDX_W`: number of samples accepted in the current window.

## Operation
- Corrected value `corr = (data_input > baseline_value) ? data_input - baseline_value : 0`. This is `DATA_W`-bit unsigned arithmetic and cannot underflow.
- FSM has two states.
  - IDLE: moves to ACCUM on `sample_en`, and that sample is accepted.
  - ACCUM: returns to IDLE on the window's last sample if `sample_en` is low on the following cycle. Otherwise it stays in ACCUM.
- On each accepted sample at count `n`:
  - If `corr > run_max`: `run_second <= run_max`, `run_max <= corr`, `run_idx <= n`.
  - Else if `corr > run_second`: `run_second <= corr`.
- Consequences of the strict `>` rule:
  - A tie with the maximum keeps the first index.
  - An equal duplicate of the maximum still raises `run_second` to that value.
- Running registers start each window at 0 and `run_idx` starts at 0. A window whose corrected values are all zero therefore reports peak 0 at index 0.
- On the `WINDOW`-th accepted sample, that sample's contribution is folded in and the final values are loaded into the result registers.
  - On the same edge, the running registers and the count reset to 0.
  - The next `sample_en` starts a new window with no gap.
- `clear` has the highest priority:
  - Running registers, `sample_count` and state go to 0 / IDLE.
  - A `sample_en` in the same cycle is dropped.
  - Result outputs hold their last reported values, and no `peak_valid` is generated.
  - If `clear` coincides with the last sample, the window is discarded.
- `sample_en` low inside a window pauses counting; the window is defined by accepted samples, not cycles.
- Reset mid-window discards the window.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Latency: results and `peak_valid` are registered. They appear on the edge that accepts the last sample and are visible for the following cycle.
- `peak_valid` is high for exactly one cycle per completed window.
- With continuous `sample_en`, `peak_valid` pulses every `WINDOW` cycles.
- `busy` and `sample_count` are registered and reflect accepted samples up to the previous edge.

## Configuration
- Macro `PEAK_WINDOW_TOP2_EN`.
- Defined: `run_second` and the `second_value` register are implemented as described.
- Undefined: they are not built, and `second_value` is tied to 0. Max and index behaviour is unchanged.

## Structure
- Shared package `peak_pkg` holds:
  - the `pk_state_t` enum (IDLE, ACCUM);
  - default width constants `PK_DATA_W=20` and `PK_WINDOW=24`.
- One combinational sub-module, `baseline_sub`, performs the saturating subtraction and is reused by other front-end blocks.

## Test plan
- Reset: assert `n_rst` low after 3 accepted samples → all outputs 0 and `busy`=0. A fresh window then completes only after `WINDOW` new samples.
- Basic run (`WINDOW`=8, baseline 5), samples 10,10,15,15,20,25,30,35 → `peak_value`=30, `second_value`=20+5=25, `peak_index`=7, `peak_valid` for one cycle after the 8th sample.
- Below baseline (baseline 175), 8 samples between 0 and 174 → `peak_value`=0, `second_value`=0, `peak_index`=0.
- Tie (`WINDOW`=4, baseline 0), samples 9,3,9,1 → `peak_value`=9, `peak_index`=0, `second_value`=9 (0 with `PEAK_WINDOW_TOP2_EN` undefined).
- Clear: 3 samples of 19876, then `clear` together with `sample_en` (value 50000 dropped), then 4 samples of 2020 (`WINDOW`=4) → a single report: peak 2020, index 0, previous results held until then.
- Back-to-back (`WINDOW`=8), 16 consecutive samples of 1..16 with baseline 0 → `peak_valid` pulses 8 cycles apart with peak 8 then 16, and `busy` stays high throughout.

Source files
------------

// File: rtl/peak_pkg.sv
// Shared types and default widths for the windowed peak detector family.
// Declarations only: no logic, no latency, no flow control.
package peak_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pk_state_t;

    localparam int PK_DATA_W = 20;
    localparam int PK_WINDOW = 24;

endpackage

// File: rtl/baseline_sub.sv
// Saturating baseline subtraction (clamps at zero); shared by front-end blocks.
// Purely combinational, zero latency; no flow control.
module baseline_sub #(
    parameter int W = 20
) (
    input  logic [W-1:0] minuend_i,
    input  logic [W-1:0] subtrahend_i,
    output logic [W-1:0] diff_o
);

    assign diff_o = (minuend_i > subtrahend_i) ? (minuend_i - subtrahend_i) : '0;

endmodule

// File: rtl/peak_window_detector.sv
// Windowed peak/index (plus runner-up under PEAK_WINDOW_TOP2_EN) over WINDOW accepted samples.
// Result registered on the edge taking the last sample; no backpressure, sample_en gaps only pause.
module peak_window_detector
    import peak_pkg::*;
#(
    parameter  int DATA_W = PK_DATA_W,
    parameter  int WINDOW = PK_WINDOW,
    localparam int IDX_W  = $clog2(WINDOW)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] baseline_value,
    input  logic [DATA_W-1:0] data_input,
    output logic [DATA_W-1:0] peak_value,
    output logic [DATA_W-1:0] second_value,
    output logic [IDX_W-1:0]  peak_index,
    output logic              peak_valid,
    output logic              busy,
    output logic [IDX_W-1:0]  sample_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

    logic [DATA_W-1:0] corr;
    pk_state_t         state_q;
    logic [IDX_W-1:0]  count_q;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic [DATA_W-1:0] peak_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic              last_smp;
`ifdef PEAK_WINDOW_TOP2_EN
    logic [DATA_W-1:0] run_second_q, run_second_d;
    logic [DATA_W-1:0] second_q;
`endif

    baseline_sub #(.W(DATA_W)) u_baseline_sub (
        .minuend_i    (data_input),
        .subtrahend_i (baseline_value),
        .diff_o       (corr)
    );

    assign last_smp = (count_q == LAST_IDX);

    // Strict '>' keeps the first index on ties; an equal duplicate still lifts the runner-up.
    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
`ifdef PEAK_WINDOW_TOP2_EN
        run_second_d = run_second_q;
        if (corr > run_max_q) begin
            run_second_d = run_max_q;
            run_max_d    = corr;
            run_idx_d    = count_q;
        end else if (corr > run_second_q) begin
            run_second_d = corr;
        end
`else
        if (corr > run_max_q) begin
            run_max_d = corr;
            run_idx_d = count_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            peak_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
`ifdef PEAK_WINDOW_TOP2_EN
            run_second_q <= '0;
            second_q     <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                state_q   <= IDLE;
                count_q   <= '0;
                run_max_q <= '0;
                run_idx_q <= '0;
`ifdef PEAK_WINDOW_TOP2_EN
                run_second_q <= '0;
`endif
            end else begin
                // ACCUM with count 0 means a window just closed; drop to IDLE only on a gap.
                case (state_q)
                    IDLE:    if (sample_en) state_q <= ACCUM;
                    ACCUM:   if (!sample_en && count_q == '0) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
                if (sample_en) begin
                    if (last_smp) begin
                        peak_q    <= run_max_d;
                        idx_q     <= run_idx_d;
                        valid_q   <= 1'b1;
                        run_max_q <= '0;
                        run_idx_q <= '0;
                        count_q   <= '0;
`ifdef PEAK_WINDOW_TOP2_EN
                        second_q     <= run_second_d;
                        run_second_q <= '0;
`endif
                    end else begin
                        run_max_q <= run_max_d;
                        run_idx_q <= run_idx_d;
                        count_q   <= count_q + 1'b1;
`ifdef PEAK_WINDOW_TOP2_EN
                        run_second_q <= run_second_d;
`endif
                    end
                end
            end
        end
    end

    assign peak_value   = peak_q;
    assign peak_index   = idx_q;
    assign peak_valid   = valid_q;
    assign busy         = (state_q == ACCUM);
    assign sample_count = count_q;
`ifdef PEAK_WINDOW_TOP2_EN
    assign second_value = second_q;
`else
    assign second_value = '0;
`endif

endmodule

// File: tb/tb_peak_window_detector.sv
// Scoreboard bench for peak_window_detector with WINDOW=8 and directed vectors.
module tb_peak_window_detector;

    localparam int DW  = 20;
    localparam int WIN = 8;
    localparam int IW  = $clog2(WIN);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          clear = 1'b0;
    logic          sample_en = 1'b0;
    logic [DW-1:0] baseline_value = '0;
    logic [DW-1:0] data_input = '0;
    logic [DW-1:0] peak_value, second_value;
    logic [IW-1:0] peak_index, sample_count;
    logic          peak_valid, busy;

    typedef struct {
        logic [DW-1:0] pk;
        logic [DW-1:0] sec;
        logic [IW-1:0] idx;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    always #5 clk = ~clk;

    peak_window_detector #(.DATA_W(DW), .WINDOW(WIN)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (clear),
        .sample_en      (sample_en),
        .baseline_value (baseline_value),
        .data_input     (data_input),
        .peak_value     (peak_value),
        .second_value   (second_value),
        .peak_index     (peak_index),
        .peak_valid     (peak_valid),
        .busy           (busy),
        .sample_count   (sample_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] sec_of(input logic [DW-1:0] v);
`ifdef PEAK_WINDOW_TOP2_EN
        return v;
`else
        return '0;
`endif
    endfunction

    task automatic expect_result(input string name, input logic [DW-1:0] pk,
                                 input logic [DW-1:0] sec, input logic [IW-1:0] idx);
        exp_t e;
        e.pk = pk; e.sec = sec_of(sec); e.idx = idx; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic smp(input logic [DW-1:0] b, input logic [DW-1:0] d);
        sample_en      = 1'b1;
        baseline_value = b;
        data_input     = d;
        @(posedge clk); #1;
        sample_en      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (peak_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_peak_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_peak"},   32'(peak_value),   32'(e.pk));
                    chk({e.name, "_second"}, 32'(second_value), 32'(e.sec));
                    chk({e.name, "_index"},  32'(peak_index),   32'(e.idx));
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] below [8];
        below = '{20'd0, 20'd174, 20'd100, 20'd50, 20'd173, 20'd1, 20'd174, 20'd10};

        idle(3);
        chk("rst_peak",   32'(peak_value),   0);
        chk("rst_second", 32'(second_value), 0);
        chk("rst_index",  32'(peak_index),   0);
        chk("rst_valid",  32'(peak_valid),   0);
        chk("rst_busy",   32'(busy),         0);
        chk("rst_count",  32'(sample_count), 0);
        n_rst = 1'b1;
        idle(2);

        // Basic: corrected 5,5,10,10,15,20,25,30 with a 2-cycle pause after 4 samples.
        expect_result("basic", 20'd30, 20'd25, 3'd7);
        smp(5, 10); smp(5, 10); smp(5, 15); smp(5, 15);
        idle(2);
        chk("pause_count", 32'(sample_count), 4);
        chk("pause_busy",  32'(busy),         1);
        smp(5, 20); smp(5, 25); smp(5, 30); smp(5, 35);
        chk("basic_valid_pulse", 32'(peak_valid), 1);
        idle(1);
        chk("basic_valid_drop", 32'(peak_valid), 0);
        idle(2);
        chk("idle_after_window_busy", 32'(busy), 0);

        // Everything at or below baseline.
        expect_result("below", 20'd0, 20'd0, 3'd0);
        for (int i = 0; i < 8; i++) smp(175, below[i]);
        idle(2);

        // Tie on the maximum: first index kept, duplicate becomes runner-up.
        expect_result("tie", 20'd9, 20'd9, 3'd0);
        smp(0, 9); smp(0, 3); smp(0, 9); smp(0, 1);
        for (int i = 0; i < 4; i++) smp(0, 0);
        idle(2);

        // Clear with a concurrent sample drops it and the partial window.
        for (int i = 0; i < 3; i++) smp(0, 19876);
        clear = 1'b1;
        smp(0, 50000);
        clear = 1'b0;
        chk("clear_count", 32'(sample_count), 0);
        chk("clear_busy",  32'(busy),         0);
        chk("clear_valid", 32'(peak_valid),   0);
        chk("clear_hold_peak",  32'(peak_value), 9);
        chk("clear_hold_index", 32'(peak_index), 0);
        expect_result("after_clear", 20'd2020, 20'd2020, 3'd0);
        for (int i = 0; i < 8; i++) smp(0, 2020);
        idle(2);

        // Clear coinciding with the last sample discards the window.
        for (int i = 0; i < 7; i++) smp(0, 777);
        clear = 1'b1;
        smp(0, 777);
        clear = 1'b0;
        chk("clear_last_valid", 32'(peak_valid),   0);
        chk("clear_last_count", 32'(sample_count), 0);
        chk("clear_last_hold",  32'(peak_value),   2020);
        idle(2);

        // Asynchronous reset mid-window.
        smp(0, 100); smp(0, 200); smp(0, 300);
        chk("pre_rst_count", 32'(sample_count), 3);
        n_rst = 1'b0;
        #2;
        chk("mid_rst_peak",   32'(peak_value),   0);
        chk("mid_rst_second", 32'(second_value), 0);
        chk("mid_rst_index",  32'(peak_index),   0);
        chk("mid_rst_busy",   32'(busy),         0);
        chk("mid_rst_count",  32'(sample_count), 0);
        idle(1);
        n_rst = 1'b1;
        idle(1);
        expect_result("fresh", 20'd8, 20'd7, 3'd7);
        for (int i = 1; i <= 8; i++) begin
            smp(0, DW'(i));
            chk("fresh_valid_timing", 32'(peak_valid), (i == 8) ? 1 : 0);
        end
        idle(2);

        // Back-to-back windows.
        expect_result("b2b_first",  20'd8,  20'd7,  3'd7);
        expect_result("b2b_second", 20'd16, 20'd15, 3'd7);
        for (int i = 1; i <= 16; i++) begin
            smp(0, DW'(i));
            chk("b2b_busy",  32'(busy),       1);
            chk("b2b_valid", 32'(peak_valid), (i % 8 == 0) ? 1 : 0);
        end
        idle(3);

        chk("pending_results", 32'(exp_q.size()), 0);
        done = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
